// File: rtl/adder_arbiter_if.sv
// Request, shared-adder and response signals of the two-client adder arbiter.
// The slave modport is the arbiter's view; master is the client/adder side.
interface adder_arbiter_if #(
   parameter int WIDTH = 4
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_A_bus;
   logic [WIDTH-1:0] req0_B_bus;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_A_bus;
   logic [WIDTH-1:0] req1_B_bus;
   logic [WIDTH-1:0] add_A_bus;
   logic [WIDTH-1:0] add_B_bus;
   logic [WIDTH-1:0] add_S_bus;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_S_bus;
   logic             resp_id;
   logic             busy;

   modport slave (
      input  req0_valid, req0_A_bus, req0_B_bus,
      output req0_ready,
      input  req1_valid, req1_A_bus, req1_B_bus,
      output req1_ready,
      output add_A_bus, add_B_bus,
      input  add_S_bus,
      output resp_valid, resp_S_bus, resp_id,
      input  resp_ready,
      output busy
   );

   modport master (
      output req0_valid, req0_A_bus, req0_B_bus,
      input  req0_ready,
      output req1_valid, req1_A_bus, req1_B_bus,
      input  req1_ready,
      input  add_A_bus, add_B_bus,
      output add_S_bus,
      input  resp_valid, resp_S_bus, resp_id,
      output resp_ready,
      input  busy
   );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one combinational adder between two requesters,
// with registered operands, a fixed settle window and a tagged response.
module adder_arbiter #(
   parameter int WIDTH         = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   adder_arbiter_if.slave bus
);
   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

   state_t           state;
   state_t           state_nxt;
   logic             last_grant;
   logic             id_q;
   logic [CNT_W-1:0] cnt;
   logic             grant0;
   logic             grant1;
   logic             accept;
   logic [WIDTH-1:0] a_sel;
   logic [WIDTH-1:0] b_sel;

   // On a tie the requester that was not served last wins.
   assign grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
   assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
   assign accept = (state == IDLE) && (grant0 || grant1);
   assign a_sel  = grant0 ? bus.req0_A_bus : bus.req1_A_bus;
   assign b_sel  = grant0 ? bus.req0_B_bus : bus.req1_B_bus;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = SETTLE;
         SETTLE:  if (cnt == '0) state_nxt = RESP;
         RESP:    if (bus.resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.req0_ready = rst_n && (state == IDLE) && grant0;
      bus.req1_ready = rst_n && (state == IDLE) && grant1;
      bus.busy       = (state != IDLE);
      bus.resp_valid = (state == RESP);
   end

   // Operand/result registers; add buses keep their value after the response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant     <= 1'b1;
         id_q           <= 1'b0;
         cnt            <= '0;
         bus.add_A_bus  <= '0;
         bus.add_B_bus  <= '0;
         bus.resp_S_bus <= '0;
         bus.resp_id    <= 1'b0;
      end else begin
         if (accept) begin
            bus.add_A_bus <= a_sel;
            bus.add_B_bus <= b_sel;
            id_q          <= grant1;
            last_grant    <= grant1;
            cnt           <= CNT_W'(SETTLE_CYCLES - 1);
         end
         if (state == SETTLE) begin
            if (cnt == '0) begin
               bus.resp_S_bus <= bus.add_S_bus;
               bus.resp_id    <= id_q;
            end else begin
               cnt <= cnt - CNT_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: one instance with a 1-cycle settle window
// and one with a 3-cycle window, each driving a behavioural adder.
module tb_adder_arbiter;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   adder_arbiter_if #(.WIDTH(4)) u_if1 ();
   adder_arbiter_if #(.WIDTH(4)) u_if3 ();

   adder_arbiter #(.WIDTH(4), .SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(u_if1)
   );
   adder_arbiter #(.WIDTH(4), .SETTLE_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(u_if3)
   );

   assign u_if1.add_S_bus = u_if1.add_A_bus + u_if1.add_B_bus;
   assign u_if3.add_S_bus = u_if3.add_A_bus + u_if3.add_B_bus;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One transaction on the 1-cycle instance with resp_ready held high.
   task automatic op(input logic v0, input logic v1,
                     input logic [3:0] a0, input logic [3:0] b0,
                     input logic [3:0] a1, input logic [3:0] b1,
                     input logic exp_id, input logic [3:0] exp_s, input bit keep);
      u_if1.req0_valid = v0; u_if1.req0_A_bus = a0; u_if1.req0_B_bus = b0;
      u_if1.req1_valid = v1; u_if1.req1_A_bus = a1; u_if1.req1_B_bus = b1;
      u_if1.resp_ready = 1'b1;
      #1;
      chk("op_ready0", u_if1.req0_ready, exp_id == 1'b0);
      chk("op_ready1", u_if1.req1_ready, exp_id == 1'b1);
      cyc();
      if (!keep) begin
         u_if1.req0_valid = 1'b0;
         u_if1.req1_valid = 1'b0;
      end
      #1;
      chk("op_settle_valid", u_if1.resp_valid, 1'b0);
      chk("op_settle_rdy", u_if1.req0_ready | u_if1.req1_ready, 1'b0);
      cyc();
      chk("op_resp_valid", u_if1.resp_valid, 1'b1);
      chk("op_resp_sum", u_if1.resp_S_bus, exp_s);
      chk("op_resp_id", u_if1.resp_id, exp_id);
      chk("op_resp_rdy", u_if1.req0_ready | u_if1.req1_ready, 1'b0);
      cyc();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      u_if1.req0_valid = 1'b1; u_if1.req0_A_bus = 4'h0; u_if1.req0_B_bus = 4'h0;
      u_if1.req1_valid = 1'b1; u_if1.req1_A_bus = 4'h0; u_if1.req1_B_bus = 4'h0;
      u_if1.resp_ready = 1'b1;
      u_if3.req0_valid = 1'b0; u_if3.req0_A_bus = 4'h0; u_if3.req0_B_bus = 4'h0;
      u_if3.req1_valid = 1'b0; u_if3.req1_A_bus = 4'h0; u_if3.req1_B_bus = 4'h0;
      u_if3.resp_ready = 1'b0;

      // Reset state
      cyc();
      cyc();
      chk("rst_ready0", u_if1.req0_ready, 1'b0);
      chk("rst_ready1", u_if1.req1_ready, 1'b0);
      chk("rst_resp_valid", u_if1.resp_valid, 1'b0);
      chk("rst_busy", u_if1.busy, 1'b0);
      chk("rst_addA", u_if1.add_A_bus, 4'h0);
      chk("rst_addB", u_if1.add_B_bus, 4'h0);
      chk("rst_respS", u_if1.resp_S_bus, 4'h0);
      chk("rst_resp_id", u_if1.resp_id, 1'b0);
      u_if1.req0_valid = 1'b0;
      u_if1.req1_valid = 1'b0;
      rst_n = 1'b1;

      // Single req0: 1+1
      u_if1.req0_valid = 1'b1; u_if1.req0_A_bus = 4'b0001; u_if1.req0_B_bus = 4'b0001;
      #1;
      chk("s_ready0", u_if1.req0_ready, 1'b1);
      chk("s_busy_acc", u_if1.busy, 1'b0);
      cyc();
      u_if1.req0_valid = 1'b0;
      #1;
      chk("s_busy_settle", u_if1.busy, 1'b1);
      chk("s_addA", u_if1.add_A_bus, 4'b0001);
      chk("s_addB", u_if1.add_B_bus, 4'b0001);
      chk("s_valid_early", u_if1.resp_valid, 1'b0);
      cyc();
      chk("s_resp_valid", u_if1.resp_valid, 1'b1);
      chk("s_resp_sum", u_if1.resp_S_bus, 4'b0010);
      chk("s_resp_id", u_if1.resp_id, 1'b0);
      chk("s_busy_resp", u_if1.busy, 1'b1);
      cyc();
      chk("s_done_valid", u_if1.resp_valid, 1'b0);
      chk("s_done_busy", u_if1.busy, 1'b0);

      // Back-to-back alternating requesters
      op(1'b0, 1'b1, 4'h0, 4'h0, 4'b0010, 4'b0001, 1'b1, 4'b0011, 1'b0);
      op(1'b1, 1'b0, 4'b0001, 4'b0011, 4'h0, 4'h0, 1'b0, 4'b0100, 1'b0);

      // Both valid continuously from reset: grants 0,1,0,1
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      op(1'b1, 1'b1, 4'b0000, 4'b0011, 4'b0011, 4'b0011, 1'b0, 4'b0011, 1'b1);
      op(1'b1, 1'b1, 4'b0000, 4'b0011, 4'b0011, 4'b0011, 1'b1, 4'b0110, 1'b1);
      op(1'b1, 1'b1, 4'b0000, 4'b0011, 4'b0011, 4'b0011, 1'b0, 4'b0011, 1'b1);
      op(1'b1, 1'b1, 4'b0000, 4'b0011, 4'b0011, 4'b0011, 1'b1, 4'b0110, 1'b1);

      // Backpressure: result held for 5 cycles, no accepts meanwhile
      u_if1.req1_valid = 1'b0;
      u_if1.resp_ready = 1'b0;
      u_if1.req0_valid = 1'b1; u_if1.req0_A_bus = 4'd5; u_if1.req0_B_bus = 4'd6;
      #1;
      chk("bp_ready0", u_if1.req0_ready, 1'b1);
      cyc();
      u_if1.req1_valid = 1'b1; u_if1.req1_A_bus = 4'd1; u_if1.req1_B_bus = 4'd1;
      cyc();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", u_if1.resp_valid, 1'b1);
         chk("bp_sum", u_if1.resp_S_bus, 4'd11);
         chk("bp_id", u_if1.resp_id, 1'b0);
         chk("bp_ready", u_if1.req0_ready | u_if1.req1_ready, 1'b0);
         cyc();
      end
      u_if1.resp_ready = 1'b1;
      #1;
      chk("bp_hs_ready", u_if1.req0_ready | u_if1.req1_ready, 1'b0);
      cyc();
      chk("bp_after_valid", u_if1.resp_valid, 1'b0);
      chk("bp_after_ready1", u_if1.req1_ready, 1'b1);
      chk("bp_after_ready0", u_if1.req0_ready, 1'b0);
      u_if1.req0_valid = 1'b0;
      u_if1.req1_valid = 1'b0;
      cyc();

      // 3-cycle settle window with wrap-around and post-accept input changes
      u_if3.resp_ready = 1'b0;
      u_if3.req0_valid = 1'b1; u_if3.req0_A_bus = 4'b1111; u_if3.req0_B_bus = 4'b0001;
      #1;
      chk("w_ready0", u_if3.req0_ready, 1'b1);
      cyc();
      u_if3.req0_valid = 1'b0; u_if3.req0_A_bus = 4'b0011; u_if3.req0_B_bus = 4'b0011;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("w_addA", u_if3.add_A_bus, 4'b1111);
         chk("w_addB", u_if3.add_B_bus, 4'b0001);
         chk("w_valid_early", u_if3.resp_valid, 1'b0);
         cyc();
      end
      chk("w_resp_valid", u_if3.resp_valid, 1'b1);
      chk("w_resp_sum", u_if3.resp_S_bus, 4'b0000);
      chk("w_resp_id", u_if3.resp_id, 1'b0);
      u_if3.resp_ready = 1'b1;
      cyc();
      chk("w_done_valid", u_if3.resp_valid, 1'b0);
      chk("w_retain_addA", u_if3.add_A_bus, 4'b1111);

      // Reset while req0 is settling: dropped, tie then goes to req0
      u_if1.req0_valid = 1'b1; u_if1.req0_A_bus = 4'd7; u_if1.req0_B_bus = 4'd2;
      #1;
      chk("m_ready0", u_if1.req0_ready, 1'b1);
      cyc();
      u_if1.req1_valid = 1'b1; u_if1.req1_A_bus = 4'd3; u_if1.req1_B_bus = 4'd4;
      rst_n = 1'b0;
      cyc();
      chk("m_valid", u_if1.resp_valid, 1'b0);
      chk("m_busy", u_if1.busy, 1'b0);
      chk("m_addA", u_if1.add_A_bus, 4'h0);
      chk("m_addB", u_if1.add_B_bus, 4'h0);
      chk("m_rst_ready", u_if1.req0_ready | u_if1.req1_ready, 1'b0);
      rst_n = 1'b1;
      #1;
      chk("m_tie_ready0", u_if1.req0_ready, 1'b1);
      chk("m_tie_ready1", u_if1.req1_ready, 1'b0);
      u_if1.req0_valid = 1'b0;
      u_if1.req1_valid = 1'b0;
      cyc();
      cyc();
      chk("m_no_resp", u_if1.resp_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
